// File: rtl/jt6295_pkg.sv
// Shared constants, lookup tables and types for the OKI ADPCM pipe decoder.
package jt6295_pkg;

   localparam int SIGW   = 12;
   localparam int IDXW   = 6;
   localparam int IDXMAX = 48;

   // OKI ADPCM step sizes, indexed by the channel step index.
   localparam logic [10:0] STEP [49] = '{
      11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
      11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
      11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
      11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
      11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
      11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
      11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
   };

   // Step-index adjustment by nibble magnitude; +8 needs five signed bits.
   localparam logic signed [4:0] ADJ [8] = '{
      -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
   };

   // Attenuation gain in 1/32 units; codes 8..15 mute the channel.
   localparam logic [5:0] GAIN [16] = '{
      6'd32, 6'd23, 6'd16, 6'd11, 6'd8, 6'd4, 6'd2, 6'd1,
      6'd0,  6'd0,  6'd0,  6'd0,  6'd0, 6'd0, 6'd0, 6'd0
   };

   // Per-channel predictor state carried around the rotation register.
   typedef struct packed {
      logic signed [SIGW-1:0] sig;
      logic [IDXW-1:0]        idx;
   } ch_state_t;

   // One slot of the serialized channel pipe.
   typedef struct packed {
      logic       en;
      logic [3:0] att;
      logic [3:0] data;
   } slot_in_t;

endpackage

// File: rtl/jt6295_dec_step.sv
// Combinational single-slot OKI ADPCM update: {sig, idx, nibble} -> {sig', idx'}.
module jt6295_dec_step
   import jt6295_pkg::*;
(
   input  ch_state_t  st_i,
   input  logic [3:0] nibble_i,
   output ch_state_t  st_o
);

   localparam logic signed [13:0] SIG_HI = 14'sd2047;
   localparam logic signed [13:0] SIG_LO = -14'sd2048;
   localparam logic signed [7:0]  IDX_HI = IDXMAX[7:0];

   logic [10:0]        step;
   logic [11:0]        diff;
   logic signed [13:0] sig_ext;
   logic signed [13:0] sig_sum;
   logic signed [4:0]  adj;
   logic signed [7:0]  idx_sum;

   // Build the delta from the step, then saturate the predictor and clamp the index.
   always_comb begin
      // NOTE: every output of this block is assigned up front so no path can infer a latch.
      st_o    = '0;
      step    = STEP[st_i.idx];
      diff    = {4'b0000, step[10:3]}
              + (nibble_i[2] ? {1'b0, step}          : 12'd0)
              + (nibble_i[1] ? {2'b00, step[10:1]}   : 12'd0)
              + (nibble_i[0] ? {3'b000, step[10:2]}  : 12'd0);
      sig_ext = signed'({{2{st_i.sig[SIGW-1]}}, st_i.sig});
      sig_sum = nibble_i[3] ? sig_ext - signed'({2'b00, diff})
                            : sig_ext + signed'({2'b00, diff});
      if (sig_sum > SIG_HI)      st_o.sig = SIG_HI[SIGW-1:0];
      else if (sig_sum < SIG_LO) st_o.sig = SIG_LO[SIGW-1:0];
      else                       st_o.sig = sig_sum[SIGW-1:0];

      adj     = ADJ[nibble_i[2:0]];
      idx_sum = signed'({2'b00, st_i.idx}) + signed'({{3{adj[4]}}, adj});
      if (idx_sum < 8'sd0)       st_o.idx = '0;
      else if (idx_sum > IDX_HI) st_o.idx = IDX_HI[IDXW-1:0];
      else                       st_o.idx = idx_sum[IDXW-1:0];
   end

endmodule

// File: rtl/jt6295_pipe_dec.sv
// Consumer of the 4-channel ADPCM pipe: decode, attenuate and mix one frame per 4 cen.
module jt6295_pipe_dec
   import jt6295_pkg::*;
#(
   parameter int OW = 14
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cen,
   input  logic                 pipe_en,
   input  logic [3:0]           pipe_att,
   input  logic [3:0]           pipe_data,
   output logic signed [OW-1:0] sound,
   output logic                 sample
);

   slot_in_t               in_q;
   ch_state_t              st_q [4];
   ch_state_t              st_d;
   ch_state_t              dec_st;
   logic [5:0]             gain;
   logic signed [16:0]     prod_full;
   logic signed [SIGW-1:0] mul_q;
   logic signed [SIGW-1:0] mul_d;
   logic signed [OW-1:0]   acc_q;
   logic [1:0]             slot_q;

   // The head of the rotation register always holds the state of the slot now in in_q.
   jt6295_dec_step u_step (
      .st_i     (st_q[3]),
      .nibble_i (in_q.data),
      .st_o     (dec_st)
   );

   // Idle slots restart their channel; otherwise take the decoded state and attenuate it.
   always_comb begin
      st_d      = '0;
      if (in_q.en) st_d = dec_st;
      gain      = GAIN[in_q.att];
      prod_full = $signed(st_d.sig) * $signed({1'b0, gain});
      mul_d     = SIGW'(prod_full >>> 5);
   end

   // Input capture, state rotation and product register, all advancing on cen.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the four state slots are plain flops and must start at {0,0}, so they are reset too.
         in_q  <= '0;
         mul_q <= '0;
         for (int i = 0; i < 4; i++) st_q[i] <= '0;
      end else if (cen) begin
         // NOTE: non-blocking updates let st_q[i] take st_q[i-1]'s old value in one edge.
         in_q     <= {pipe_en, pipe_att, pipe_data};
         mul_q    <= mul_d;
         st_q[0]  <= st_d;
         for (int i = 1; i < 4; i++) st_q[i] <= st_q[i-1];
      end
   end

   // Mixer: sum four products per window, publish on the last slot with a one-clk strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         slot_q <= '0;
         sound  <= '0;
         sample <= 1'b0;
      end else begin
         sample <= 1'b0;
         if (cen) begin
            slot_q <= slot_q + 2'd1;
            if (slot_q == 2'd3) begin
               sound  <= acc_q + OW'(mul_q);
               acc_q  <= '0;
               sample <= 1'b1;
            end else begin
               acc_q  <= acc_q + OW'(mul_q);
            end
         end
      end
   end

endmodule

// File: tb/tb_jt6295_pipe_dec.sv
// Self-checking bench for jt6295_pipe_dec: behavioural channel model plus directed literal cases.
`timescale 1ns/1ps
module tb_jt6295_pipe_dec;

   localparam int OW = 14;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 cen;
   logic                 pipe_en;
   logic [3:0]           pipe_att;
   logic [3:0]           pipe_data;
   logic signed [OW-1:0] sound;
   logic                 sample;

   int checks   = 0;
   int failures = 0;
   int samples_seen = 0;

   jt6295_pipe_dec #(.OW(OW)) dut (
      .clk       (clk),
      .rst       (rst),
      .cen       (cen),
      .pipe_en   (pipe_en),
      .pipe_att  (pipe_att),
      .pipe_data (pipe_data),
      .sound     (sound),
      .sample    (sample)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int step_tab [49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,
                         107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,
                         449,494,544,598,658,724,796,876,963,1060,1166,1282,1411,1552};
   int adj_tab  [8]  = '{-1,-1,-1,-1,2,4,6,8};
   int gain_tab [16] = '{32,23,16,11,8,4,2,1,0,0,0,0,0,0,0,0};

   int m_sig [4];
   int m_idx [4];
   int ring  [8];
   int m_k;
   int exp_sound;
   int exp_sample;
   bit m_valid = 1'b0;

   // Update channel c with one slot and return its attenuated contribution.
   function automatic int model_slot(input int c, input int en, input int att, input int d);
      int st, diff, s, ix;
      if (en == 0) begin
         m_sig[c] = 0;
         m_idx[c] = 0;
         return 0;
      end
      st   = step_tab[m_idx[c]];
      diff = st / 8 + (((d & 4) != 0) ? st : 0) + (((d & 2) != 0) ? st / 2 : 0)
           + (((d & 1) != 0) ? st / 4 : 0);
      s    = ((d & 8) != 0) ? m_sig[c] - diff : m_sig[c] + diff;
      if (s > 2047)  s = 2047;
      if (s < -2048) s = -2048;
      ix   = m_idx[c] + adj_tab[d & 7];
      if (ix < 0)  ix = 0;
      if (ix > 48) ix = 48;
      m_sig[c] = s;
      m_idx[c] = ix;
      return (s * gain_tab[att]) >>> 5;
   endfunction

   // Compare outputs after each edge, then predict the next edge from the now-stable inputs.
   always @(negedge clk) begin
      int sum;
      if (m_valid) begin
         check("model_sound",  int'(sound), exp_sound);
         check("model_sample", int'(sample), exp_sample);
      end
      if (rst) begin
         for (int i = 0; i < 4; i++) begin m_sig[i] = 0; m_idx[i] = 0; end
         for (int i = 0; i < 8; i++) ring[i] = 0;
         m_k        = 0;
         exp_sound  = 0;
         exp_sample = 0;
         m_valid    = 1'b1;
      end else if (cen) begin
         ring[m_k % 8] = model_slot(m_k % 4, int'(pipe_en), int'(pipe_att), int'(pipe_data));
         if (m_k % 4 == 3) begin
            sum = 0;
            for (int j = 2; j <= 5; j++) sum += ring[(m_k + 8 - j) % 8];
            exp_sound  = sum;
            exp_sample = 1;
         end else begin
            exp_sample = 0;
         end
         m_k++;
      end else begin
         exp_sample = 0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input bit c, input bit en, input int att, input int d);
      cen       = c;
      pipe_en   = en;
      pipe_att  = 4'(att);
      pipe_data = 4'(d);
      @(posedge clk);
      #1;
      if (sample) samples_seen++;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 15), $urandom_range(0, 15));
      rst = 1'b0;
   endtask

   // One slot per channel (ch0 in the low nibble), with random idle clocks in between.
   task automatic frame(input logic [3:0] en, input logic [15:0] att, input logic [15:0] d);
      for (int c = 0; c < 4; c++) begin
         if ($urandom_range(0, 3) == 0)
            cyc(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15));
         cyc(1'b1, en[c], int'(att[4*c +: 4]), int'(d[4*c +: 4]));
      end
   endtask

   initial begin
      rst = 1'b1; cen = 1'b0; pipe_en = 1'b0; pipe_att = '0; pipe_data = '0;

      // Reset and an idle frame.
      do_reset(3);
      check("rst_sound", int'(sound), 0);
      check("rst_sample", int'(sample), 0);
      samples_seen = 0;
      frame(4'b0000, 16'h0000, 16'h0000);
      check("idle_sound", int'(sound), 0);
      check("idle_samples", samples_seen, 1);

      // Single channel decode from reset.
      frame(4'b0001, 16'h0000, 16'h0000);
      check("ch0_nib0", int'(sound), 2);
      frame(4'b0001, 16'h0000, 16'h0007);
      check("ch0_nib7", int'(sound), 32);

      // Reset mid-frame with a partial accumulation pending.
      cyc(1'b1, 1'b1, 0, 7);
      cyc(1'b1, 1'b0, 0, 0);
      cyc(1'b1, 1'b0, 0, 0);
      do_reset(3);
      check("midrst_sound", int'(sound), 0);
      check("midrst_sample", int'(sample), 0);
      frame(4'b0000, 16'h0000, 16'h0000);
      check("midrst_frame", int'(sound), 0);

      // Negative step and attenuation.
      frame(4'b0001, 16'h0000, 16'h0008);
      check("neg_nib8", int'(sound), -2);
      frame(4'b0001, 16'h0002, 16'h0007);
      check("att2", int'(sound), 14);
      frame(4'b0001, 16'h0008, 16'h0007);
      check("att8_mute", int'(sound), 0);
      frame(4'b0001, 16'h0000, 16'h0000);
      check("att_state_kept", int'(sound), 100);

      // Saturation at both rails, index clamp at 48.
      do_reset(3);
      repeat (60) frame(4'b0001, 16'h0000, 16'h0007);
      check("sat_hi", int'(sound), 2047);
      frame(4'b0001, 16'h0000, 16'h000F);
      check("sat_step1552", int'(sound), -863);
      repeat (60) frame(4'b0001, 16'h0000, 16'h000F);
      check("sat_lo", int'(sound), -2048);

      // Four-channel mix and channel drop.
      do_reset(3);
      repeat (60) frame(4'b1111, 16'h0000, 16'h7777);
      check("mix_full", int'(sound), 8188);
      frame(4'b1110, 16'h0000, 16'h7777);
      check("mix_drop", int'(sound), 6141);
      frame(4'b1111, 16'h0000, 16'h7770);
      check("mix_restart", int'(sound), 6143);

      // Latency: nibbles at cen 5 and 6; only cen 5 may land in the window closing at cen 7.
      do_reset(3);
      samples_seen = 0;
      for (int k = 0; k < 12; k++) begin
         cyc(1'b1, (k == 5 || k == 6), 0, (k == 5 || k == 6) ? 7 : 0);
         if (k == 6)  check("lat_before", int'(sound), 0);
         if (k == 7)  check("lat_k2", int'(sound), 30);
         if (k == 11) check("lat_next", int'(sound), 30);
      end
      check("lat_samples", samples_seen, 3);

      // Randomized traffic against the model, with occasional resets.
      do_reset(3);
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 199) == 0)
            do_reset($urandom_range(1, 3));
         else
            cyc($urandom_range(0, 2) != 0, $urandom_range(0, 7) != 0,
                ($urandom_range(0, 3) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7),
                $urandom_range(0, 15));
      end

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
